// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Single-clock byte FIFO after the UART receiver. Read data is
//            registered, and a sticky flag records words dropped while full.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
   parameter int DATA_BITS = 8,
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk_50MHz,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 empty,
   output logic                 full,
   output logic [ADDR_BITS:0]   count,
   output logic                 overflow,
   input  logic                 clear_overflow
);

   localparam int DEPTH = 2**ADDR_BITS;
   localparam logic [ADDR_BITS:0] c_DEPTH = (ADDR_BITS+1)'(DEPTH);

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [ADDR_BITS-1:0] wp_q, wp_d;
   logic [ADDR_BITS-1:0] rp_q, rp_d;
   logic [ADDR_BITS:0]   count_q, count_d;
   logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 overflow_q, overflow_d;

   logic w_empty, w_full, w_rd_acc, w_wr_acc, w_drop;

   assign w_empty  = (count_q == '0);
   assign w_full   = (count_q == c_DEPTH);
   assign w_rd_acc = rd_en && !w_empty;
   // At full, a same-cycle read frees the slot the write is about to use.
   assign w_wr_acc = wr_en && (!w_full || w_rd_acc);
   assign w_drop   = wr_en && !w_wr_acc;

   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      overflow_d = overflow_q;

      if (w_wr_acc) begin
         wp_d = wp_q + 1'b1;
      end
      if (w_rd_acc) begin
         rp_d       = rp_q + 1'b1;
         rd_data_d  = mem_q[rp_q];
         rd_valid_d = 1'b1;
      end

      case ({w_wr_acc, w_rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (w_drop) begin
         overflow_d = 1'b1;
      end else if (clear_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left out of reset; the pointers alone define content.
   always_ff @(posedge clk_50MHz) begin
      if (w_wr_acc) begin
         mem_q[wp_q] <= wr_data;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign empty    = w_empty;
   assign full     = w_full;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo;

   logic       clk_50MHz = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       clear_overflow;

   uart_rx_fifo #(.DATA_BITS(8), .ADDR_BITS(4)) dut (
      .clk_50MHz      (clk_50MHz),
      .reset          (reset),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .empty          (empty),
      .full           (full),
      .count          (count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: a plain queue of stored bytes plus the visible read state.
   logic [7:0] model_q [$];
   logic       m_ovf      = 1'b0;
   logic       m_rd_valid = 1'b0;
   logic [7:0] m_rd_data  = 8'h00;

   logic [16:0] dut_status;
   assign dut_status = {count, empty, full, overflow, rd_valid, rd_data};

   function automatic logic [16:0] exp_status();
      return {5'(model_q.size()), model_q.size() == 0, model_q.size() == 16,
              m_ovf, m_rd_valid, m_rd_data};
   endfunction

   task automatic model_reset();
      model_q.delete();
      m_ovf      = 1'b0;
      m_rd_valid = 1'b0;
      m_rd_data  = 8'h00;
   endtask

   // One clock of stimulus; returns #1 after the edge with inputs idled.
   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic clr);
      logic racc, wacc;
      wr_en = w; wr_data = d; rd_en = r; clear_overflow = clr;
      racc = r && (model_q.size() != 0);
      wacc = w && ((model_q.size() < 16) || racc);
      @(posedge clk_50MHz);
      m_rd_valid = racc;
      if (racc) m_rd_data = model_q.pop_front();
      if (wacc) model_q.push_back(d);
      if (w && !wacc) m_ovf = 1'b1;
      else if (clr)   m_ovf = 1'b0;
      #1;
      wr_en = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clear_overflow = 1'b0;
      repeat (2) @(posedge clk_50MHz);
      #1;
      vectors++;
      if (dut_status !== 17'b00000_1_0_0_0_00000000) begin
         miscompares++;
         $display("FAIL reset_power_up: got %h expected %h", dut_status, 17'b00000_1_0_0_0_00000000);
      end
      reset = 1'b0;
      model_reset();
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      vectors++;
      if (dut_status !== exp_status()) begin
         miscompares++;
         $display("FAIL reset_preload: got %h expected %h", dut_status, exp_status());
      end
      #5 reset = 1'b1;
      #1;
      model_reset();
      vectors++;
      if (dut_status !== 17'b00000_1_0_0_0_00000000) begin
         miscompares++;
         $display("FAIL reset_async: got %h expected %h", dut_status, 17'b00000_1_0_0_0_00000000);
      end
      @(posedge clk_50MHz);
      #1 reset = 1'b0;
   endtask

   task automatic test_order();
      logic [7:0] exp_b;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
         vectors++;
         if (count !== 5'(i + 1) || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL order_write%0d: count %0d empty %b expected %0d 0", i, count, empty, i + 1);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         exp_b = 8'h41 + 8'(i);
         vectors++;
         if (rd_valid !== 1'b1 || rd_data !== exp_b || count !== 5'(2 - i)) begin
            miscompares++;
            $display("FAIL order_read%0d: valid %b data %h count %0d expected 1 %h %0d",
                     i, rd_valid, rd_data, count, exp_b, 2 - i);
         end
      end
      vectors++;
      if (empty !== 1'b1) begin
         miscompares++;
         $display("FAIL order_empty: got %b expected 1", empty);
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      vectors++;
      if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: full %b count %0d ovf %b expected 1 16 0", full, count, overflow);
      end
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      vectors++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         miscompares++;
         $display("FAIL fill_overflow: ovf %b count %0d expected 1 16", overflow, count);
      end
      step(1'b1, 8'hBB, 1'b0, 1'b1);
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_set_wins: got %b expected 1", overflow);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         vectors++;
         if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
            miscompares++;
            $display("FAIL fill_drain%0d: valid %b data %h expected 1 %h", i, rd_valid, rd_data, 8'(i));
         end
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      vectors++;
      if (overflow !== 1'b0 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_clear: ovf %b empty %b expected 0 1", overflow, empty);
      end
   endtask

   task automatic test_simultaneous_full();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      vectors++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL simfull_rw: data %h valid %b count %0d ovf %b expected 00 1 16 0",
                  rd_data, rd_valid, count, overflow);
      end
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         vectors++;
         if (rd_data !== ((i == 16) ? 8'h55 : 8'(i))) begin
            miscompares++;
            $display("FAIL simfull_drain%0d: got %h expected %h", i, rd_data,
                     (i == 16) ? 8'h55 : 8'(i));
         end
      end
   endtask

   task automatic test_simultaneous_empty();
      step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rd_valid !== 1'b0 || rd_data !== 8'h55 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL underflow: valid %b data %h empty %b expected 0 55 1", rd_valid, rd_data, empty);
      end
      step(1'b1, 8'h77, 1'b1, 1'b0);
      vectors++;
      if (count !== 5'd1 || rd_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL simempty_rw: count %0d valid %b expected 1 0", count, rd_valid);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd0) begin
         miscompares++;
         $display("FAIL simempty_read: valid %b data %h count %0d expected 1 77 0", rd_valid, rd_data, count);
      end
   endtask

   task automatic test_wrap_reset();
      int writes = 0;
      int guard  = 0;
      logic w;
      while (writes < 40 && guard < 2000) begin
         guard++;
         w = ($urandom_range(0, 2) != 0);
         step(w, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         if (w) writes++;
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL wrap_stream: got %h expected %h", dut_status, exp_status());
         end
      end
      while (model_q.size() != 0 && guard < 2100) begin
         guard++;
         step(1'b0, 8'h00, 1'b1, 1'b0);
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL wrap_drain: got %h expected %h", dut_status, exp_status());
         end
      end
      for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      #5 reset = 1'b1;
      #1;
      model_reset();
      vectors++;
      if (count !== 5'd0 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_reset: count %0d empty %b expected 0 1", count, empty);
      end
      @(posedge clk_50MHz);
      #1 reset = 1'b0;
      step(1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h99 || empty !== 1'b1) begin
         miscompares++;
         $display("FAIL midop_after: valid %b data %h empty %b expected 1 99 1", rd_valid, rd_data, empty);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 7) == 0));
         vectors++;
         if (dut_status !== exp_status()) begin
            miscompares++;
            $display("FAIL random%0d: got %h expected %h", i, dut_status, exp_status());
         end
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_fill_overflow();
      test_simultaneous_full();
      test_simultaneous_empty();
      test_wrap_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
